// File: rtl/lsu_pkg.sv
// LSU shared definitions: access-op encodings, error codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and memory-side command/return bundle.
interface lsu_req_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [1:0]      resp_err_code;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
    );
    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
    );
endinterface

interface lsu_mem_if #(parameter int XLEN = 32);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment: store strobe/shift, load extract/extend, legality checks.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   ld_data,
    output logic [1:0]        err_code
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [OW-1:0]   off;
    logic [NB-1:0]   bmask;
    logic [XLEN-1:0] lane;
    logic            illegal;
    logic            misal;

    assign off       = addr[OW-1:0];
    assign mem_addr  = {addr[XLEN-1:OW], {OW{1'b0}}};
    assign mem_wdata = wdata << {off, 3'b000};
    assign wstrb     = bmask << off;
    assign lane      = rdata >> {off, 3'b000};

    always_comb begin
        bmask = '0;
        misal = 1'b0;
        unique case (op[1:0])
            2'b00: bmask = NB'(8'h01);
            2'b01: begin
                bmask = NB'(8'h03);
                misal = addr[0];
            end
            2'b10: begin
                bmask = NB'(8'h0F);
                misal = |addr[1:0];
            end
            2'b11: begin
                bmask = NB'(8'hFF);
                misal = |addr[2:0];
            end
        endcase
    end

    always_comb begin
        ld_data = rdata;
        unique case (op)
            OP_B:    ld_data = XLEN'($signed(lane[7:0]));
            OP_H:    ld_data = XLEN'($signed(lane[15:0]));
            OP_W:    ld_data = XLEN'($signed(lane[31:0]));
            OP_BU:   ld_data = XLEN'(lane[7:0]);
            OP_HU:   ld_data = XLEN'(lane[15:0]);
            OP_WU:   ld_data = XLEN'(lane[31:0]);
            default: ld_data = rdata;
        endcase
    end

    // An illegal op outranks misalignment when both apply.
    assign illegal = (op == 3'b111)
                  || (XLEN == 32 && (op == OP_D || op == OP_WU))
                  || (we && op[2]);

    always_comb begin
        err_code = ERR_NONE;
        priority case (1'b1)
            illegal: err_code = ERR_ILLEGAL;
            misal:   err_code = ERR_MISALIGN;
            default: err_code = ERR_NONE;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between core and a req/gnt memory port.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  core,
    lsu_mem_if.master mem
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    state_t state, nxt;

    logic            we_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [1:0]      code_q;

    logic            idle;
    logic            sel_we;
    logic [2:0]      sel_op;
    logic [XLEN-1:0] sel_addr, sel_wdata;

    logic [XLEN-1:0]   a_addr, a_wdata, ld_data;
    logic [XLEN/8-1:0] a_wstrb;
    logic [1:0]        chk_code;

    logic            lat_en, set_resp, clr_resp, cnt_clr, cnt_inc;
    logic [XLEN-1:0] nrdata;
    logic            nerr;
    logic [1:0]      ncode;

    // Checks look at the incoming request in IDLE, the latched one after.
    assign idle      = (state == S_IDLE);
    assign sel_we    = idle ? core.req_we    : we_q;
    assign sel_op    = idle ? core.req_op    : op_q;
    assign sel_addr  = idle ? core.req_addr  : addr_q;
    assign sel_wdata = idle ? core.req_wdata : wdata_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .we        (sel_we),
        .op        (sel_op),
        .addr      (sel_addr),
        .wdata     (sel_wdata),
        .rdata     (mem.mem_rdata),
        .mem_addr  (a_addr),
        .wstrb     (a_wstrb),
        .mem_wdata (a_wdata),
        .ld_data   (ld_data),
        .err_code  (chk_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        lat_en   = 1'b0;
        set_resp = 1'b0;
        clr_resp = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        nrdata   = '0;
        nerr     = 1'b0;
        ncode    = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                if (core.req_valid) begin
                    lat_en = 1'b1;
                    if (chk_code == ERR_NONE) begin
                        nxt = S_REQ;
                    end else begin
                        nxt      = S_RESP;
                        set_resp = 1'b1;
                        nerr     = 1'b1;
                        ncode    = chk_code;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    if (we_q) begin
                        nxt      = S_RESP;
                        set_resp = 1'b1;
                    end else begin
                        nxt     = S_WAIT;
                        cnt_clr = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    nxt      = S_RESP;
                    set_resp = 1'b1;
                    nrdata   = ld_data;
                end else if (TIMEOUT != 0 && cnt == TLAST) begin
                    nxt      = S_RESP;
                    set_resp = 1'b1;
                    nerr     = 1'b1;
                    ncode    = ERR_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (core.resp_ready) begin
                    nxt      = S_IDLE;
                    clr_resp = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            if (lat_en) begin
                we_q    <= core.req_we;
                op_q    <= core.req_op;
                addr_q  <= core.req_addr;
                wdata_q <= core.req_wdata;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CW'(1);
            if (set_resp) begin
                rdata_q <= nrdata;
                err_q   <= nerr;
                code_q  <= ncode;
            end else if (clr_resp) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
                code_q  <= ERR_NONE;
            end
        end
    end

    assign core.req_ready     = idle;
    assign core.resp_valid    = (state == S_RESP);
    assign core.resp_rdata    = rdata_q;
    assign core.resp_err      = err_q;
    assign core.resp_err_code = code_q;

    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = (state == S_REQ) && we_q;
    assign mem.mem_addr  = (state == S_REQ) ? a_addr  : '0;
    assign mem.mem_wstrb = (state == S_REQ) ? a_wstrb : '0;
    assign mem.mem_wdata = (state == S_REQ) ? a_wdata : '0;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench: XLEN=32/TIMEOUT=4 and XLEN=64/TIMEOUT=6 instances side by side.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          lat;
    } resp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        d_valid[2], d_we[2], d_rready[2], d_gnt[2], d_rvalid[2];
    logic [2:0]  d_op[2];
    logic [63:0] d_addr[2], d_wdata[2], d_rdata[2];

    logic        o_ready[2], o_rvalid[2], o_err[2], o_mreq[2], o_mwe[2];
    logic [1:0]  o_code[2];
    logic [63:0] o_rdata[2], o_maddr[2], o_mwdata[2];
    logic [7:0]  o_wstrb[2];

    lsu_req_if #(.XLEN(32)) c0();
    lsu_mem_if #(.XLEN(32)) m0();
    lsu_req_if #(.XLEN(64)) c1();
    lsu_mem_if #(.XLEN(64)) m1();

    assign c0.req_valid  = d_valid[0];
    assign c0.req_we     = d_we[0];
    assign c0.req_op     = d_op[0];
    assign c0.req_addr   = d_addr[0][31:0];
    assign c0.req_wdata  = d_wdata[0][31:0];
    assign c0.resp_ready = d_rready[0];
    assign m0.mem_gnt    = d_gnt[0];
    assign m0.mem_rvalid = d_rvalid[0];
    assign m0.mem_rdata  = d_rdata[0][31:0];
    assign o_ready[0]    = c0.req_ready;
    assign o_rvalid[0]   = c0.resp_valid;
    assign o_rdata[0]    = {32'h0, c0.resp_rdata};
    assign o_err[0]      = c0.resp_err;
    assign o_code[0]     = c0.resp_err_code;
    assign o_mreq[0]     = m0.mem_req;
    assign o_mwe[0]      = m0.mem_we;
    assign o_maddr[0]    = {32'h0, m0.mem_addr};
    assign o_wstrb[0]    = {4'h0, m0.mem_wstrb};
    assign o_mwdata[0]   = {32'h0, m0.mem_wdata};

    assign c1.req_valid  = d_valid[1];
    assign c1.req_we     = d_we[1];
    assign c1.req_op     = d_op[1];
    assign c1.req_addr   = d_addr[1];
    assign c1.req_wdata  = d_wdata[1];
    assign c1.resp_ready = d_rready[1];
    assign m1.mem_gnt    = d_gnt[1];
    assign m1.mem_rvalid = d_rvalid[1];
    assign m1.mem_rdata  = d_rdata[1];
    assign o_ready[1]    = c1.req_ready;
    assign o_rvalid[1]   = c1.resp_valid;
    assign o_rdata[1]    = c1.resp_rdata;
    assign o_err[1]      = c1.resp_err;
    assign o_code[1]     = c1.resp_err_code;
    assign o_mreq[1]     = m1.mem_req;
    assign o_mwe[1]      = m1.mem_we;
    assign o_maddr[1]    = m1.mem_addr;
    assign o_wstrb[1]    = m1.mem_wstrb;
    assign o_mwdata[1]   = m1.mem_wdata;

    lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (c0.slave),
        .mem   (m0.master)
    );

    lsu #(.XLEN(64), .TIMEOUT(6)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (c1.slave),
        .mem   (m1.master)
    );

    resp_t rq[2][$];
    cmd_t  cq[2][$];
    int    acc[2];
    bit    seen[2];

    function automatic void chk(int d, string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d act=%h exp=%h", nm, d, act, exp);
        end
    endfunction

    function automatic void bad(int d, string nm);
        checks++;
        errors++;
        $display("FAIL %s dut%0d act=expired exp=event", nm, d);
    endfunction

    // Reference behaviour from the access rules, in plain arithmetic.
    function automatic void model(
        input int xl, input logic we, input logic [2:0] op,
        input logic [63:0] addr, input logic [63:0] wdata,
        input logic [63:0] rdata, input bit tmo,
        output resp_t r, output cmd_t c, output bit legal
    );
        int nb, off, sz;
        logic [63:0] xm, m, v;
        bit ill, mis;
        nb  = xl / 8;
        off = int'(addr % 64'(nb));
        sz  = 1 << op[1:0];
        xm  = (xl == 64) ? '1 : 64'hFFFF_FFFF;
        m   = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        ill = (op == 3'd7) || (xl == 32 && (op == 3'd3 || op == 3'd6))
           || (we && op >= 3'd4);
        mis = (addr % 64'(sz)) != 0;
        legal = !ill && !mis;
        r.rdata = '0;
        r.err   = !legal;
        r.code  = ill ? 2'd2 : (mis ? 2'd1 : 2'd0);
        r.lat   = 0;
        c.we    = we;
        c.addr  = addr - 64'(off);
        c.strb  = 8'(((16'd1 << sz) - 16'd1) << off);
        c.wdata = (wdata << (8 * off)) & xm;
        if (legal && !we) begin
            if (tmo) begin
                r.err  = 1'b1;
                r.code = 2'd3;
            end else if (op == 3'd3) begin
                r.rdata = rdata & xm;
            end else begin
                v = ((rdata & xm) >> (8 * off)) & m;
                if (op < 3'd3 && v[8*sz-1]) v = v | ~m;
                r.rdata = v & xm;
            end
        end
    endfunction

    resp_t me;
    cmd_t  mc;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (d_valid[d] && o_ready[d]) begin
                    acc[d]  = cyc;
                    seen[d] = 1'b0;
                end
                if (o_rvalid[d]) begin
                    if (rq[d].size() == 0) begin
                        bad(d, "unexpected_resp");
                    end else begin
                        me = rq[d][0];
                        chk(d, "resp_rdata", o_rdata[d], me.rdata);
                        chk(d, "resp_err", 64'(o_err[d]), 64'(me.err));
                        chk(d, "resp_code", 64'(o_code[d]), 64'(me.code));
                        chk(d, "ready_busy", 64'(o_ready[d]), 64'd0);
                        if (!seen[d]) begin
                            chk(d, "latency", 64'(cyc - acc[d]), 64'(me.lat));
                            seen[d] = 1'b1;
                        end
                        if (d_rready[d]) begin
                            void'(rq[d].pop_front());
                            seen[d] = 1'b0;
                        end
                    end
                end
                if (o_mreq[d]) begin
                    if (cq[d].size() == 0) begin
                        bad(d, "unexpected_mem_req");
                    end else begin
                        mc = cq[d][0];
                        chk(d, "mem_we", 64'(o_mwe[d]), 64'(mc.we));
                        chk(d, "mem_addr", o_maddr[d], mc.addr);
                        chk(d, "mem_wstrb", 64'(o_wstrb[d]), 64'(mc.strb));
                        chk(d, "mem_wdata", o_mwdata[d], mc.wdata);
                        if (d_gnt[d]) void'(cq[d].pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(
        input int d, input logic we, input logic [2:0] op,
        input logic [63:0] addr, input logic [63:0] wdata,
        input logic [63:0] rdata, input int g, input int r,
        input bit tmo, input int hold, input bit early
    );
        resp_t e;
        cmd_t  c;
        bit    legal;
        int    n;
        model(d ? 64 : 32, we, op, addr, wdata, rdata, tmo, e, c, legal);
        if (!legal)  e.lat = 1;
        else if (we) e.lat = 2 + g;
        else if (tmo) e.lat = 2 + g + (d ? 6 : 4);
        else         e.lat = 3 + g + r;
        rq[d].push_back(e);
        if (legal) cq[d].push_back(c);
        d_we[d]    = we;
        d_op[d]    = op;
        d_addr[d]  = addr;
        d_wdata[d] = wdata;
        d_valid[d] = 1'b1;
        n = 0;
        while (!o_ready[d] && n < 50) begin step(); n++; end
        if (n >= 50) bad(d, "accept_wait");
        step();
        d_valid[d] = 1'b0;
        if (legal) begin
            n = 0;
            while (!o_mreq[d] && n < 50) begin step(); n++; end
            if (n >= 50) bad(d, "mem_req_wait");
            repeat (g) step();
            d_gnt[d] = 1'b1;
            if (early && !we) begin
                d_rvalid[d] = 1'b1;
                d_rdata[d]  = ~rdata;
            end
            step();
            d_gnt[d]    = 1'b0;
            d_rvalid[d] = 1'b0;
            if (!we && !tmo) begin
                repeat (r) step();
                d_rvalid[d] = 1'b1;
                d_rdata[d]  = rdata;
                step();
                d_rvalid[d] = 1'b0;
            end
        end
        n = 0;
        while (!o_rvalid[d] && n < 100) begin step(); n++; end
        if (n >= 100) bad(d, "resp_wait");
        repeat (hold) step();
        d_rready[d] = 1'b1;
        step();
        d_rready[d] = 1'b0;
        if (tmo) begin
            d_rvalid[d] = 1'b1;
            d_rdata[d]  = rdata;
            step();
            d_rvalid[d] = 1'b0;
        end
    endtask

    task automatic rst_chk(input int d);
        chk(d, "rst_req_ready", 64'(o_ready[d]), 64'd1);
        chk(d, "rst_resp_valid", 64'(o_rvalid[d]), 64'd0);
        chk(d, "rst_resp_rdata", o_rdata[d], 64'd0);
        chk(d, "rst_resp_err", 64'(o_err[d]), 64'd0);
        chk(d, "rst_resp_code", 64'(o_code[d]), 64'd0);
        chk(d, "rst_mem_req", 64'(o_mreq[d]), 64'd0);
        chk(d, "rst_mem_we", 64'(o_mwe[d]), 64'd0);
        chk(d, "rst_mem_addr", o_maddr[d], 64'd0);
        chk(d, "rst_mem_wstrb", 64'(o_wstrb[d]), 64'd0);
        chk(d, "rst_mem_wdata", o_mwdata[d], 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog dut0 act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d, g, r, hold, n;
        logic        we;
        logic [2:0]  op;
        logic [63:0] addr, wd, rd;
        bit          tmo, early, legal;
        resp_t       e;
        cmd_t        c;

        for (int i = 0; i < 2; i++) begin
            d_valid[i] = 1'b0; d_we[i] = 1'b0; d_rready[i] = 1'b0;
            d_gnt[i] = 1'b0; d_rvalid[i] = 1'b0; d_op[i] = '0;
            d_addr[i] = '0; d_wdata[i] = '0; d_rdata[i] = '0;
            acc[i] = 0; seen[i] = 1'b0;
        end
        #1;
        rst_chk(0);
        rst_chk(1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        rst_chk(0);
        rst_chk(1);

        txn(0, 1, OP_B, 64'h1003, 64'hAB, 0, 0, 0, 0, 0, 0);
        txn(0, 0, OP_B, 64'h2001, 64'h0, 64'h80FF, 0, 0, 0, 0, 0);
        txn(0, 0, OP_BU, 64'h2001, 64'h0, 64'h80FF, 0, 0, 0, 0, 0);
        txn(0, 0, OP_W, 64'h3002, 64'h0, 64'h0, 0, 0, 0, 0, 0);
        txn(0, 0, OP_D, 64'h3000, 64'h0, 64'h0, 0, 0, 0, 0, 0);
        txn(0, 0, OP_W, 64'h3000, 64'h0, 64'hDEAD_BEEF, 0, 0, 1, 0, 0);
        txn(0, 0, OP_H, 64'h2002, 64'h0, 64'h8001_0000, 1, 0, 0, 5, 0);
        txn(0, 0, OP_HU, 64'h2002, 64'h0, 64'h8001_0000, 0, 2, 0, 0, 1);
        txn(0, 1, OP_BU, 64'h2000, 64'h12, 64'h0, 0, 0, 0, 0, 0);
        txn(0, 1, OP_W, 64'h2004, 64'h1234_5678, 64'h0, 3, 0, 0, 1, 0);
        txn(1, 0, OP_WU, 64'h4004, 64'h0, 64'h8000_0001_1234_5678, 0, 0, 0, 0, 0);
        txn(1, 0, OP_W, 64'h4004, 64'h0, 64'h8000_0001_1234_5678, 0, 0, 0, 0, 0);
        txn(1, 0, OP_D, 64'h4008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 1, 0, 0, 1);
        txn(1, 1, OP_D, 64'h4004, 64'h1, 64'h0, 0, 0, 0, 0, 0);
        txn(1, 1, OP_H, 64'h4006, 64'hBEEF, 64'h0, 0, 0, 0, 0, 0);
        txn(1, 0, OP_B, 64'h4000, 64'h0, 64'h0, 1, 0, 1, 0, 0);

        model(32, 0, OP_W, 64'h5000, 64'h0, 64'h0, 0, e, c, legal);
        cq[0].push_back(c);
        d_we[0] = 1'b0; d_op[0] = OP_W; d_addr[0] = 64'h5000; d_wdata[0] = '0;
        d_valid[0] = 1'b1;
        step();
        d_valid[0] = 1'b0;
        n = 0;
        while (!o_mreq[0] && n < 50) begin step(); n++; end
        if (n >= 50) bad(0, "mem_req_wait");
        d_gnt[0] = 1'b1;
        step();
        d_gnt[0] = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 rst_chk(0);
        step();
        rst_n = 1'b1;
        repeat (10) step();

        for (int i = 0; i < 80; i++) begin
            d     = i % 2;
            we    = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            addr  = d ? {32'($urandom), 32'($urandom)} : {32'h0, 32'($urandom)};
            if ($urandom_range(0, 2) != 0) addr[2:0] = 3'($urandom_range(0, 1) * 4);
            wd    = {32'($urandom), 32'($urandom)};
            rd    = {32'($urandom), 32'($urandom)};
            g     = $urandom_range(0, 2);
            r     = $urandom_range(0, 2);
            hold  = $urandom_range(0, 2);
            early = 1'($urandom_range(0, 1));
            tmo   = !we && ($urandom_range(0, 7) == 0);
            txn(d, we, op, addr, wd, rd, g, r, tmo, hold, early);
        end

        repeat (5) step();
        for (int i = 0; i < 2; i++) begin
            chk(i, "resp_queue_empty", 64'(rq[i].size()), 64'd0);
            chk(i, "cmd_queue_empty", 64'(cq[i].size()), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for mem_rvalid after grant; 0 disables the timeout.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  core request valid.
REQ-007 req_ready  out  1  LSU accepts request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_op  in  3  access type, RV funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 req_addr  in  XLEN  byte address.
REQ-011 req_wdata  in  XLEN  store data, LSB-aligned.
REQ-012 resp_valid  out  1  response valid.
REQ-013 resp_ready  in  1  core accepts response.
REQ-014 resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1  access failed.
REQ-016 resp_err_code  out  2  00 none, 01 misaligned, 10 illegal op, 11 timeout.
REQ-017 mem_req / mem_gnt  out / in  1 / 1  memory request handshake.
REQ-018 mem_we, mem_addr, mem_wstrb, mem_wdata  out  1, XLEN, XLEN/8, XLEN  memory command; mem_addr aligned down to XLEN/8 bytes.
REQ-019 mem_rvalid, mem_rdata  in  1, XLEN  memory read return, full aligned word.

Function
REQ-020 FSM states IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid, latch we/op/addr/wdata; a legal aligned request goes to REQ next cycle; any other request goes directly to RESP with resp_err=1 and no mem_req.
REQ-022 Illegal ops: 111 always; 011 and 110 when XLEN=32; 1xx with req_we=1 (error code 10, takes precedence over misalignment).
REQ-023 Misaligned: H/HU addr[0]!=0; W/WU addr[1:0]!=0; D addr[2:0]!=0 (error code 01).
REQ-024 REQ: mem_req=1 with stable command until mem_gnt; on grant a store goes to RESP and a load goes to WAIT.
REQ-025 Store lanes: mem_wstrb has size bytes set starting at lane addr offset; mem_wdata is req_wdata shifted left by 8*offset.
REQ-026 WAIT: on mem_rvalid, select bytes at the offset, sign-extend (B/H/W) or zero-extend (BU/HU/WU), then go to RESP; D passes through unchanged.
REQ-027 WAIT timeout: a counter clears on entry and increments each cycle without rvalid; when it reaches TIMEOUT (if nonzero), go to RESP with error code 11; a late mem_rvalid in IDLE is discarded.
REQ-028 RESP: resp_valid=1, outputs held stable until resp_ready; on handshake return to IDLE, so the next request is accepted no earlier than the following cycle.
REQ-029 Minimum latency: store acceptance to resp_valid is 2 cycles with gnt in the first REQ cycle; load is 3 cycles with gnt and rvalid immediate.
REQ-030 mem_rvalid in the same cycle as mem_gnt SHALL be ignored; rvalid is counted only in WAIT.
REQ-031 Only one transaction in flight; no reordering or buffering beyond one request.

Reset
REQ-032 On rst_n low (asynchronous), FSM is IDLE and the timeout counter and all latched request fields are 0.
REQ-033 Reset values: req_ready=1 after deassertion; resp_valid, resp_err, resp_err_code, resp_rdata, mem_req, mem_we, mem_wstrb, mem_addr and mem_wdata are all 0.
REQ-034 Reset mid-transaction aborts it with no response; the memory side treats the dropped mem_req as cancelled.

Structure
REQ-035 Shared package lsu_pkg holds the op encoding constants, error code constants, and FSM state enum.
REQ-036 One sub-module lsu_align: combinational lane-offset/wstrb/wdata shift, load extract/extend, and misalign/illegal checks; the FSM stays in lsu.

Verification
REQ-037 XLEN=32, SB addr 0x1003 wdata 0x000000AB, gnt immediate -> mem_addr 0x1000, wstrb 1000, wdata 0xAB000000, resp after 2 cycles, err=0.
REQ-038 LB addr 0x2001, mem_rdata 0x0000_80FF -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LW addr 0x3002 -> no mem_req, resp_err=1, code 01; LD with XLEN=32 -> code 10.
REQ-040 TIMEOUT=4, LW with no rvalid -> resp_err code 11 exactly 4 cycles after entering WAIT; later rvalid ignored.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout; rst_n asserted mid-WAIT -> all outputs return to reset values immediately.
REQ-042 XLEN=64, LWU addr 0x4004, mem_rdata 0x8000_0001_xxxx_xxxx -> resp_rdata 0x0000_0000_8000_0001.
